// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: block geometry, padder state encoding, word/block types.
package sha1_pkg;

    localparam int SHA1_BLK_WORDS = 16;
    // First byte position of the 64-bit length field within a block.
    localparam int SHA1_LEN_POS   = 56;

    typedef logic [31:0]                   sha1_word_t;
    // Element [i] is message schedule word W_i.
    typedef sha1_word_t [SHA1_BLK_WORDS-1:0] sha1_blk_t;

    typedef enum logic [2:0] {
        FILL,
        PAD,
        ISSUE,
        WAIT,
        EXTRA
    } sha1_state_e;

    // Keep the first nbytes bytes (MSB-aligned) of a word, zero the rest.
    function automatic sha1_word_t sha1_byte_mask(input logic [2:0] nbytes);
        sha1_word_t m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(nbytes)) begin
                m[31-8*k -: 8] = 8'hff;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs big-endian words into 512-bit blocks, appends the
// 0x80 marker, zero fill and 64-bit bit length, and hands blocks to the core.
module sha1_padder
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_data,
    input  logic [2:0]  s_bytes,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output sha1_blk_t   sha_data,
    output logic        sha_start,
    output logic        sha_use_prev_cv,
    input  logic        sha_out_valid,
    output logic        msg_done
);

    sha1_state_e state_q, state_d;
    sha1_blk_t   blk_q, blk_d;
    logic [60:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        first_q, first_d;
    logic        need_extra_q, need_extra_d;
    logic        is_last_q, is_last_d;
    logic [2:0]  last_bytes_q, last_bytes_d;
    // The 0x80 marker did not fit (p = 64) and belongs in the extra block's W0.
    logic        pad_in_extra_q, pad_in_extra_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;

    logic [6:0]  pad_pos;
    logic [63:0] bit_len;
    logic        accept;

    assign pad_pos = {1'b0, wcnt_q, 2'b00} + {4'b0000, last_bytes_q};
    assign bit_len = {byte_cnt_q, 3'b000};
    assign accept  = s_valid && ready_q;

    // Next-state, buffer update and padding mux.
    always_comb begin
        state_d        = state_q;
        blk_d          = blk_q;
        byte_cnt_d     = byte_cnt_q;
        wcnt_d         = wcnt_q;
        first_d        = first_q;
        need_extra_d   = need_extra_q;
        is_last_d      = is_last_q;
        last_bytes_d   = last_bytes_q;
        pad_in_extra_d = pad_in_extra_q;
        done_d         = 1'b0;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    blk_d[wcnt_q] = s_data & sha1_byte_mask(s_bytes);
                    byte_cnt_d    = byte_cnt_q + 61'(s_bytes);
                    if (s_last) begin
                        last_bytes_d = s_bytes;
                        state_d      = PAD;
                    end else if (wcnt_q == 4'd15) begin
                        is_last_d = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            PAD: begin
                for (int i = 0; i < SHA1_BLK_WORDS; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        if (4*i + j == int'(pad_pos)) begin
                            blk_d[i][31-8*j -: 8] = 8'h80;
                        end else if (4*i + j > int'(pad_pos)) begin
                            blk_d[i][31-8*j -: 8] = 8'h00;
                        end
                    end
                end
                if (int'(pad_pos) < SHA1_LEN_POS) begin
                    blk_d[14]      = bit_len[63:32];
                    blk_d[15]      = bit_len[31:0];
                    is_last_d      = 1'b1;
                    need_extra_d   = 1'b0;
                    pad_in_extra_d = 1'b0;
                end else begin
                    is_last_d      = 1'b0;
                    need_extra_d   = 1'b1;
                    pad_in_extra_d = (pad_pos == 7'd64);
                end
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (sha_out_valid) begin
                    first_d = 1'b0;
                    if (need_extra_q) begin
                        state_d = EXTRA;
                    end else if (is_last_q) begin
                        done_d     = 1'b1;
                        byte_cnt_d = '0;
                        wcnt_d     = '0;
                        blk_d      = '0;
                        is_last_d  = 1'b0;
                        first_d    = 1'b1;
                        state_d    = FILL;
                    end else begin
                        wcnt_d  = '0;
                        blk_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            EXTRA: begin
                blk_d          = '0;
                blk_d[0]       = pad_in_extra_q ? 32'h8000_0000 : 32'h0000_0000;
                blk_d[14]      = bit_len[63:32];
                blk_d[15]      = bit_len[31:0];
                need_extra_d   = 1'b0;
                pad_in_extra_d = 1'b0;
                is_last_d      = 1'b1;
                state_d        = ISSUE;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // Registered so s_ready stays low for the first cycle out of reset.
        ready_d = (state_d == FILL);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= FILL;
            blk_q          <= '0;
            byte_cnt_q     <= '0;
            wcnt_q         <= '0;
            first_q        <= 1'b1;
            need_extra_q   <= 1'b0;
            is_last_q      <= 1'b0;
            last_bytes_q   <= '0;
            pad_in_extra_q <= 1'b0;
            ready_q        <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            blk_q          <= blk_d;
            byte_cnt_q     <= byte_cnt_d;
            wcnt_q         <= wcnt_d;
            first_q        <= first_d;
            need_extra_q   <= need_extra_d;
            is_last_q      <= is_last_d;
            last_bytes_q   <= last_bytes_d;
            pad_in_extra_q <= pad_in_extra_d;
            ready_q        <= ready_d;
            done_q         <= done_d;
        end
    end

    // Output decode; buffer and first flag are held until WAIT exits.
    always_comb begin
        s_ready         = ready_q;
        sha_data        = blk_q;
        sha_start       = (state_q == ISSUE);
        sha_use_prev_cv = ~first_q;
        msg_done        = done_q;
    end

endmodule

// File: tb/tb_sha1_padder.sv
// Scoreboard bench for sha1_padder: a byte-level padding model predicts every
// block, a core model answers start pulses, and a monitor checks what the DUT issues.
module tb_sha1_padder;
    import sha1_pkg::*;

    typedef byte unsigned byte_q_t[$];

    typedef struct packed {
        logic [511:0] data;
        logic         prev;
        logic         last;
        logic         refill;
        logic         extra;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [31:0] s_data;
    logic [2:0]  s_bytes;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    sha1_blk_t   sha_data;
    logic        sha_start;
    logic        sha_use_prev_cv;
    logic        sha_out_valid;
    logic        msg_done;

    int   tests;
    int   fails;
    int   cyc;
    int   ov_rise_cyc;
    int   msgs_sent;
    int   done_cnt;
    bit   core_busy;
    bit   hold20;
    exp_t exp_q[$];
    exp_t cur;

    sha1_padder dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_data         (s_data),
        .s_bytes        (s_bytes),
        .s_last         (s_last),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .sha_data       (sha_data),
        .sha_start      (sha_start),
        .sha_use_prev_cv(sha_use_prev_cv),
        .sha_out_valid  (sha_out_valid),
        .msg_done       (msg_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: message bytes + 0x80 + zeros to 56 mod 64 + 64-bit bit length.
    task automatic push_expected(input byte_q_t m);
        byte unsigned    p[$];
        longint unsigned bits;
        int              nblk;
        exp_t            rec;
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = longint'(m.size()) * 8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            rec.data = '0;
            for (int w = 0; w < 16; w++) begin
                for (int k = 0; k < 4; k++) begin
                    rec.data[32*w + 24 - 8*k +: 8] = p[64*b + 4*w + k];
                end
            end
            rec.prev   = (b != 0);
            rec.last   = (b == nblk - 1);
            rec.refill = rec.last || (m.size() > 64 * (b + 1));
            rec.extra  = (b != 0) && (m.size() <= 64 * b);
            exp_q.push_back(rec);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        bit got;
        int t;
        s_data  = d;
        s_bytes = nb;
        s_last  = last;
        s_valid = 1'b1;
        got     = 1'b0;
        t       = 0;
        while (!got) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            #1;
            t++;
            if (t > 3000) begin
                fails++;
                $display("FAIL send_timeout: s_ready never high after %0d cycles", t);
                $fatal(1, "input handshake stuck");
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_msg(input byte_q_t m);
        int          n;
        int          idx;
        int          nb;
        logic [31:0] w;
        n   = m.size();
        idx = 0;
        push_expected(m);
        msgs_sent++;
        if (n == 0) begin
            send_word($urandom, 3'd0, 1'b1);
        end else begin
            while (idx < n) begin
                nb = (n - idx >= 4) ? 4 : n - idx;
                w  = $urandom;
                for (int k = 0; k < nb; k++) w[31-8*k -: 8] = m[idx + k];
                send_word(w, 3'(nb), (idx + nb) == n);
                idx += nb;
            end
        end
    endtask

    task automatic rand_msg(input int len, output byte_q_t m);
        m = {};
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((done_cnt < msgs_sent || exp_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("msgs_completed", done_cnt, msgs_sent);
        check("blocks_consumed", exp_q.size(), 0);
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_sha_start", sha_start, 1'b0);
        check("rst_use_prev_cv", sha_use_prev_cv, 1'b0);
        check("rst_msg_done", msg_done, 1'b0);
        check("rst_sha_data", sha_data, '0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("ready_low_first_cycle", s_ready, 1'b0);
        @(negedge clk);
        check("ready_rises", s_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Core model: clears out_valid on start, raises it after a random latency.
    initial begin
        int d;
        sha_out_valid = 1'b0;
        core_busy     = 1'b0;
        ov_rise_cyc   = -10;
        forever begin
            @(negedge clk);
            if (rstn && sha_start) begin
                sha_out_valid = 1'b0;
                core_busy     = 1'b1;
                d = hold20 ? 20 : $urandom_range(0, 4);
                repeat (d + 1) @(posedge clk);
                #1;
                sha_out_valid = 1'b1;
                ov_rise_cyc   = cyc;
                core_busy     = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each start and checks timing/handshakes.
    initial begin
        exp_t rec;
        bit   prev_start;
        int   wcount;
        int   exp_start_cyc;
        prev_start    = 1'b0;
        wcount        = 0;
        exp_start_cyc = -1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_start    = 1'b0;
                wcount        = 0;
                exp_start_cyc = -1;
                continue;
            end
            if (sha_start) begin
                check("start_gap", prev_start, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", sha_start, 1'b0);
                end else begin
                    rec = exp_q.pop_front();
                    check("block_data", sha_data, rec.data);
                    check("use_prev_cv", sha_use_prev_cv, rec.prev);
                    if (rec.extra) check("extra_start_timing", cyc, ov_rise_cyc + 2);
                    else           check("start_timing", cyc, exp_start_cyc);
                    cur = rec;
                end
                wcount = 0;
            end else if (core_busy) begin
                check("ready_low_in_wait", s_ready, 1'b0);
                check("block_hold", sha_data, cur.data);
                check("prev_cv_hold", sha_use_prev_cv, cur.prev);
            end
            if (cyc == ov_rise_cyc + 1) begin
                check("ready_after_block", s_ready, cur.refill);
            end
            if (msg_done || cyc == ov_rise_cyc + 1) begin
                check("msg_done", msg_done, (cyc == ov_rise_cyc + 1) && cur.last);
            end
            if (msg_done) done_cnt++;
            if (s_valid && s_ready) begin
                if (s_last)            exp_start_cyc = cyc + 2;
                else if (wcount == 15) exp_start_cyc = cyc + 1;
                wcount++;
            end
            prev_start = sha_start;
        end
    end

    initial begin
        byte_q_t m;
        tests     = 0;
        fails     = 0;
        msgs_sent = 0;
        done_cnt  = 0;
        hold20    = 1'b0;
        cur       = '0;
        rstn      = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_data    = '0;
        s_bytes   = '0;
        repeat (3) @(posedge clk);
        check_reset_values();
        release_reset();

        m = {};
        send_msg(m);
        wait_idle();

        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        wait_idle();

        rand_msg(55, m);
        send_msg(m);
        wait_idle();

        rand_msg(56, m);
        send_msg(m);
        wait_idle();

        hold20 = 1'b1;
        rand_msg(64, m);
        send_msg(m);
        wait_idle();
        hold20 = 1'b0;

        // Abort a message after five words; nothing should be issued for it.
        for (int i = 0; i < 5; i++) send_word($urandom, 3'd4, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values();
        release_reset();

        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        wait_idle();

        foreach (m[i]) m[i] = 8'h00;
        for (int i = 0; i < 10; i++) begin
            rand_msg($urandom_range(0, 140), m);
            send_msg(m);
        end
        rand_msg(128, m);
        send_msg(m);
        rand_msg(119, m);
        send_msg(m);
        wait_idle();

        repeat (10) @(posedge clk);
        #1;
        check("final_done_count", done_cnt, msgs_sent);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha1_padder.md
# sha1_padder

Upstream feeder for the SHA-1 core wrapper (`top`). It accepts a message as a stream of big-endian 32-bit words and assembles 512-bit blocks. It applies SHA-1 padding: a 0x80 byte, zero fill, and the 64-bit big-endian bit length. It issues each block with a one-cycle start pulse and waits for the core's `out_valid` before issuing the next, driving `use_prev_cv` so that only the first block of a message uses the external IV.

## Interface
Parameters:
- none (block size 16 words, length field 64 bits: fixed by SHA-1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- s_data  in  32  message word, first byte in [31:24]
- s_bytes  in  3  valid bytes in s_data (0..4, MSB-aligned); must be 4 unless s_last; 0 only with s_last
- s_last  in  1  final word of message
- s_valid  in  1  word present
- s_ready  out  1  word accepted when s_valid && s_ready
- sha_data  out  16x32  block to core; element [i] = W_i
- sha_start  out  1  one-cycle block start pulse, to core `start`
- sha_use_prev_cv  out  1  0 for first block of message, 1 otherwise
- sha_out_valid  in  1  core `out_valid` (level, cleared by start)
- msg_done  out  1  one-cycle pulse when final block's hash is valid

## Operation
- State register byte_cnt: 61 bits, wraps mod 2^61; bit length = byte_cnt<<3.
- State register wcnt: 0..15.
- State register first: 1 after reset and after msg_done.
- State register need_extra.
- State register is_last.
- FILL: s_ready=1. Accepted word masked to s_bytes (invalid bytes zero) is written to buf[wcnt]; byte_cnt += s_bytes.
  - Non-last word and wcnt=15 -> ISSUE, is_last=0.
  - Non-last word and wcnt<15 -> wcnt++.
  - s_last -> PAD.
- PAD (1 cycle): pad byte position p = 4*wcnt+s_bytes of the last word.
  - Write 0x80 at p. If s_bytes=4 it lands in buf[wcnt+1][31:24].
  - Zero all bytes after p.
  - If p<=55: write bit length to W14 (high) and W15 (low); is_last=1.
  - Otherwise (p>=56): need_extra=1, is_last=0. If p=64, the 0x80 goes into the extra block's W0.
  - Go to ISSUE.
- ISSUE: sha_start=1 for exactly one cycle; sha_use_prev_cv=~first; then WAIT.
- WAIT: hold buffer. On sha_out_valid=1, first<=0, then:
  - need_extra -> EXTRA.
  - is_last -> msg_done pulse, clear all counters, first<=1 -> FILL.
  - else wcnt<=0, buffer cleared -> FILL.
- EXTRA (1 cycle): buffer = zeros. W0=0x80000000 only if p was 64. W14/W15 = length. need_extra<=0, is_last<=1 -> ISSUE.
- sha_data and sha_use_prev_cv stay stable from ISSUE until WAIT exits.

## Timing
- Reset values:
  - s_ready=0, sha_start=0, sha_use_prev_cv=0, msg_done=0.
  - sha_data=0, state=FILL, counters 0, first=1.
  - s_ready rises the cycle after rstn deasserts.
- 16th word accepted at cycle N: ISSUE (start pulse) at N+1.
- s_last accepted at N: PAD at N+1, start at N+2.
- sha_out_valid seen in WAIT at M:
  - Final block: msg_done at M+1, s_ready at M+1.
  - Non-final block: s_ready at M+1.
  - Extra block: start at M+2.
- sha_out_valid is ignored outside WAIT. WAIT is entered the cycle after start, when the core has already cleared it.
- Reset mid-message (any state) aborts. The core is not notified; the next start restarts it.
- No back-to-back blocks: at least one idle cycle between start pulses.

## Structure
- Shared package sha1_pkg:
  - SHA1_BLK_WORDS=16.
  - SHA1_LEN_POS=56.
  - State enum {FILL,PAD,ISSUE,WAIT,EXTRA}.
  - Word/block typedefs, also used by `top`.
- Single flat module. Padding mux stays inline; no sub-module.

## Test plan
- Empty message (one beat, s_bytes=0, s_last) -> one block: W0=0x80000000, W1..W15=0; use_prev_cv=0; msg_done once.
- "abc" (0x61626300, bytes=3, last) -> W0=0x61626380, W15=0x00000018, others 0.
- 55-byte message -> single block: 0x80 at byte 55, W15=0x000001B8.
- 56-byte message -> two blocks. Block 1: byte 56=0x80, rest zero. Block 2: W0..W13=0, W15=0x000001C0, use_prev_cv=1.
- 64-byte message -> two blocks. Block 2: W0=0x80000000, W15=0x00000200. s_ready=0 throughout both WAITs while sha_out_valid held 0 for 20 cycles.
- rstn low mid-FILL after 5 words -> all outputs at reset values. Next "abc" yields first=1 and the same block as the "abc" test.
